// File: rtl/ram_fifo_cfg.sv
// ---------------------------------------------------------------------------
// ram_fifo_cfg
// Parametrised single-clock FIFO buffering words between bus-side writers and
// peripheral-side readers. Offers an exact occupancy count, programmable
// almost-full / almost-empty thresholds, standard or first-word-fall-through
// read mode, sticky overflow / underflow flags and a synchronous flush.
//
// Ports
//   clk_sys         system clock, all logic on the rising edge
//   rst_sys         synchronous active-high reset (priority over flush_i)
//   flush_i         synchronous clear of pointers, count, flags and read data
//   write_enable_i  push request
//   data_in         push data
//   read_enable_i   pop request
//   data_out        read data (registered in standard mode, head word in FWFT)
//   rx_ack_o        high in the cycle after each accepted pop
//   empty_o         count == 0
//   full_o          count == DEPTH
//   almost_empty_o  count <= AEMPTY_TH
//   almost_full_o   count >= AFULL_TH
//   count_o         current occupancy
//   overflow_o      sticky: a push was rejected while full
//   underflow_o     sticky: a pop was rejected while empty
// ---------------------------------------------------------------------------
module ram_fifo_cfg #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                         clk_sys,
   input  logic                         rst_sys,
   input  logic                         flush_i,
   input  logic                         write_enable_i,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         read_enable_i,
   output logic [WIDTH-1:0]             data_out,
   output logic                         rx_ack_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic                         almost_empty_o,
   output logic                         almost_full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         overflow_o,
   output logic                         underflow_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_writePtr;
   logic [PW-1:0]    r_readPtr;
   logic [CW-1:0]    r_count;
   logic             r_ack;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_empty;
   logic             w_full;
   logic             w_popAccept;
   logic             w_pushAccept;
   logic             w_live;
   logic             w_doPop;
   logic             w_doPush;

   // Pointers wrap explicitly so that a non-power-of-two DEPTH works.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
      if (ptr == PW'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PW'(1);
   endfunction

   // Acceptance is judged on the registered count, so a push into an empty
   // FIFO cannot be popped in the same cycle, while a push into a full FIFO
   // succeeds when a pop frees a slot at the same edge. Reset and flush
   // drop any request in their cycle.
   always_comb begin
      w_empty      = (r_count == '0);
      w_full       = (r_count == CW'(DEPTH));
      w_popAccept  = read_enable_i && !w_empty;
      w_pushAccept = write_enable_i && (!w_full || w_popAccept);
      w_live       = !rst_sys && !flush_i;
      w_doPop      = w_live && w_popAccept;
      w_doPush     = w_live && w_pushAccept;
   end

   // Storage array; contents survive reset and flush, only pointers move.
   always_ff @(posedge clk_sys) begin
      if (w_doPush) begin
         r_mem[r_writePtr] <= data_in;
      end
   end

   // Pointers, occupancy, acknowledge and sticky error flags.
   always_ff @(posedge clk_sys) begin
      if (rst_sys || flush_i) begin
         r_writePtr  <= '0;
         r_readPtr   <= '0;
         r_count     <= '0;
         r_ack       <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_ack <= w_popAccept;
         if (w_pushAccept) begin
            r_writePtr <= nextPtr(r_writePtr);
         end
         if (w_popAccept) begin
            r_readPtr <= nextPtr(r_readPtr);
         end
         case ({w_pushAccept, w_popAccept})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (write_enable_i && !w_pushAccept) begin
            r_overflow <= 1'b1;
         end
         if (read_enable_i && !w_popAccept) begin
            r_underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT == 0) begin : gen_std
         logic [WIDTH-1:0] r_dataOut;

         // Standard mode: the head word is captured at the pop edge and
         // held until the next accepted pop.
         always_ff @(posedge clk_sys) begin
            if (rst_sys || flush_i) begin
               r_dataOut <= '0;
            end else if (w_popAccept) begin
               r_dataOut <= r_mem[r_readPtr];
            end
         end

         assign data_out = r_dataOut;
      end else begin : gen_fwft
         // FWFT mode: the head word is presented directly; forced to zero
         // while empty so stale storage never leaks out.
         always_comb begin
            data_out = '0;
            if (!w_empty) begin
               data_out = r_mem[r_readPtr];
            end
         end
      end
   endgenerate

   always_comb begin
      rx_ack_o       = r_ack;
      empty_o        = w_empty;
      full_o         = w_full;
      almost_empty_o = (r_count <= CW'(AEMPTY_TH));
      almost_full_o  = (r_count >= CW'(AFULL_TH));
      count_o        = r_count;
      overflow_o     = r_overflow;
      underflow_o    = r_underflow;
   end

endmodule

// File: tb/tb_ram_fifo_cfg.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_cfg
// Drives three FIFO configurations with one shared input stream:
//   A: DEPTH=4, standard read, AFULL_TH=3, AEMPTY_TH=1
//   B: DEPTH=5, standard read, default thresholds (3 / 2)
//   C: DEPTH=4, FWFT read, AFULL_TH=4, AEMPTY_TH=0
// Each instance is tracked by a list-based behavioural model, and all
// outputs are compared once per cycle, 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_ram_fifo_cfg;

   logic       clk = 1'b0;
   logic       rstIn = 1'b1;
   logic       flushIn = 1'b0;
   logic       weIn = 1'b0;
   logic       reIn = 1'b0;
   logic [7:0] dinIn = 8'h00;

   logic [7:0] dOut  [3];
   logic [2:0] cntO  [3];
   logic       ackO  [3];
   logic       emptyO[3];
   logic       fullO [3];
   logic       aeO   [3];
   logic       afO   [3];
   logic       ovfO  [3];
   logic       unfO  [3];

   int checkCount = 0;
   int failCount  = 0;

   // Model state: each FIFO is a plain list, head at index 0
   int         mDepth[3] = '{4, 5, 4};
   int         mFwft [3] = '{0, 0, 1};
   int         mAf   [3] = '{3, 3, 4};
   int         mAe   [3] = '{1, 2, 0};
   string      mName [3] = '{"A", "B", "C"};
   logic [7:0] mData [3][8];
   int         mCount[3] = '{0, 0, 0};
   logic [7:0] mDout [3] = '{8'h00, 8'h00, 8'h00};
   logic       mAck  [3] = '{1'b0, 1'b0, 1'b0};
   logic       mOvf  [3] = '{1'b0, 1'b0, 1'b0};
   logic       mUnf  [3] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   ram_fifo_cfg #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) dutA (
      .clk_sys(clk), .rst_sys(rstIn), .flush_i(flushIn),
      .write_enable_i(weIn), .data_in(dinIn), .read_enable_i(reIn),
      .data_out(dOut[0]), .rx_ack_o(ackO[0]), .empty_o(emptyO[0]), .full_o(fullO[0]),
      .almost_empty_o(aeO[0]), .almost_full_o(afO[0]), .count_o(cntO[0]),
      .overflow_o(ovfO[0]), .underflow_o(unfO[0]));

   ram_fifo_cfg #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dutB (
      .clk_sys(clk), .rst_sys(rstIn), .flush_i(flushIn),
      .write_enable_i(weIn), .data_in(dinIn), .read_enable_i(reIn),
      .data_out(dOut[1]), .rx_ack_o(ackO[1]), .empty_o(emptyO[1]), .full_o(fullO[1]),
      .almost_empty_o(aeO[1]), .almost_full_o(afO[1]), .count_o(cntO[1]),
      .overflow_o(ovfO[1]), .underflow_o(unfO[1]));

   ram_fifo_cfg #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(0)) dutC (
      .clk_sys(clk), .rst_sys(rstIn), .flush_i(flushIn),
      .write_enable_i(weIn), .data_in(dinIn), .read_enable_i(reIn),
      .data_out(dOut[2]), .rx_ack_o(ackO[2]), .empty_o(emptyO[2]), .full_o(fullO[2]),
      .almost_empty_o(aeO[2]), .almost_full_o(afO[2]), .count_o(cntO[2]),
      .overflow_o(ovfO[2]), .underflow_o(unfO[2]));

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance every model by one edge using the inputs held during that edge
   task automatic modelStep();
      bit popOk;
      bit pushOk;
      for (int i = 0; i < 3; i++) begin
         if (rstIn || flushIn) begin
            mCount[i] = 0;
            mAck[i]   = 1'b0;
            mDout[i]  = 8'h00;
            mOvf[i]   = 1'b0;
            mUnf[i]   = 1'b0;
         end else begin
            popOk  = reIn && (mCount[i] > 0);
            pushOk = weIn && ((mCount[i] < mDepth[i]) || popOk);
            if (weIn && !pushOk) mOvf[i] = 1'b1;
            if (reIn && !popOk)  mUnf[i] = 1'b1;
            mAck[i] = popOk;
            if (popOk) begin
               if (mFwft[i] == 0) mDout[i] = mData[i][0];
               for (int k = 0; k < 7; k++) mData[i][k] = mData[i][k+1];
               mCount[i]--;
            end
            if (pushOk) begin
               mData[i][mCount[i]] = dinIn;
               mCount[i]++;
            end
         end
         if (mFwft[i] != 0) mDout[i] = (mCount[i] > 0) ? mData[i][0] : 8'h00;
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 3; i++) begin
         checkOutput({mName[i], ".count"},     32'(cntO[i]),   32'(mCount[i]));
         checkOutput({mName[i], ".empty"},     32'(emptyO[i]), 32'(mCount[i] == 0));
         checkOutput({mName[i], ".full"},      32'(fullO[i]),  32'(mCount[i] == mDepth[i]));
         checkOutput({mName[i], ".almEmpty"},  32'(aeO[i]),    32'(mCount[i] <= mAe[i]));
         checkOutput({mName[i], ".almFull"},   32'(afO[i]),    32'(mCount[i] >= mAf[i]));
         checkOutput({mName[i], ".overflow"},  32'(ovfO[i]),   32'(mOvf[i]));
         checkOutput({mName[i], ".underflow"}, 32'(unfO[i]),   32'(mUnf[i]));
         checkOutput({mName[i], ".ack"},       32'(ackO[i]),   32'(mAck[i]));
         checkOutput({mName[i], ".dataOut"},   32'(dOut[i]),   32'(mDout[i]));
      end
   endtask

   // Drive one cycle of inputs, update the models at the edge, then compare
   task automatic applyStimulus(input logic we, input logic [7:0] din, input logic re,
                                input logic fl, input logic rs);
      weIn    = we;
      dinIn   = din;
      reIn    = re;
      flushIn = fl;
      rstIn   = rs;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   initial begin
      logic [7:0] seq [4];
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};

      $display("[TB] start");
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("A.resetEmpty", 32'(emptyO[0]), 32'd1);

      // Fill to full, then drain in order
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
      checkOutput("A.fullAfterFill", 32'(fullO[0]), 32'd1);
      checkOutput("A.countAfterFill", 32'(cntO[0]), 32'd4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("A.drainData", 32'(dOut[0]), 32'(seq[i]));
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Overflow while full, then write-while-full with simultaneous pop
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      checkOutput("A.overflowSet", 32'(ovfO[0]), 32'd1);
      applyStimulus(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      checkOutput("A.pushPopData", 32'(dOut[0]), 32'h11);
      checkOutput("A.pushPopCount", 32'(cntO[0]), 32'd4);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("A.lastIs66", 32'(dOut[0]), 32'h66);

      // Push and pop together into an empty FIFO
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      checkOutput("A.underflowSet", 32'(unfO[0]), 32'd1);
      checkOutput("C.fwftHeadAA", 32'(dOut[2]), 32'hAA);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("A.popAA", 32'(dOut[0]), 32'hAA);

      // Interleaved push/pop pairs wrap every pointer several times
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end

      // Count 3 with overflow set, then flush with push and pop requested
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
      checkOutput("A.flushOverflow", 32'(ovfO[0]), 32'd0);
      checkOutput("A.flushCount", 32'(cntO[0]), 32'd0);

      // Reset mid-stream, then reset together with flush
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h98, 1'b1, 1'b1, 1'b1);

      // Randomised traffic with occasional flush and reset
      for (int n = 0; n < 600; n++) begin
         applyStimulus(1'($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 39) == 0),
                       1'($urandom_range(0, 79) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
